// File: rtl/wt931_pkg.sv
// Shared constants and FSM encoding for the WT931 IMU frame parser.
package wt931_pkg;
  localparam logic [7:0] WT931_HDR = 8'h55;
  localparam logic [7:0] TYPE_ACC  = 8'h51;
  localparam logic [7:0] TYPE_GYR  = 8'h52;
  localparam logic [7:0] TYPE_ANG  = 8'h53;
  localparam int WT931_PAYLOAD_LEN = 8;

  typedef enum logic [1:0] {HUNT, TYPE, PAYLOAD, CKSUM} wt931_state_e;
endpackage

// File: rtl/wt931_gap_timer.sv
// Idle-gap counter: counts enabled cycles since the last clear and pulses expire
// on the cycle the count sits at CYCLES-1 with no clear pending.
module wt931_gap_timer #(
  parameter int unsigned CYCLES = 8680
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = en && !clr && (cnt_q == W'(CYCLES - 1));
    cnt_d  = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/wt931_frame_parser.sv
// Hunts 11-byte WT931 frames in the UART byte stream, validates the checksum, latches
// accel/gyro/angle/temperature words one cycle after the checksum byte, and counts errors.
module wt931_frame_parser
  import wt931_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8680,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 clr_cnt,
  output logic [47:0]          acc_data,
  output logic [47:0]          gyr_data,
  output logic [47:0]          ang_data,
  output logic [15:0]          temp_data,
  output logic [2:0]           upd,
  output logic [ERR_CNT_W-1:0] cksum_err_cnt,
  output logic [ERR_CNT_W-1:0] tmo_err_cnt,
  output logic                 in_frame
);
  wt931_state_e state_q, state_d;
  logic [7:0] type_q, type_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [WT931_PAYLOAD_LEN-1:0][7:0] pay_q, pay_d;
  logic [47:0] acc_q, acc_d, gyr_q, gyr_d, ang_q, ang_d;
  logic [15:0] temp_q, temp_d;
  logic [2:0]  upd_q, upd_d;
  logic [ERR_CNT_W-1:0] cks_q, cks_d, tmo_q, tmo_d;
  logic cks_inc, tmo_inc;
  logic gap_clr, gap_en, gap_expire;

  assign gap_clr = rx_valid || (state_q == HUNT);
  assign gap_en  = (state_q != HUNT);

  wt931_gap_timer #(.CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clk    (ACLK),
    .rst    (ARESET),
    .clr    (gap_clr),
    .en     (gap_en),
    .expire (gap_expire)
  );

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    pay_d   = pay_q;
    acc_d   = acc_q;
    gyr_d   = gyr_q;
    ang_d   = ang_q;
    temp_d  = temp_q;
    upd_d   = '0;
    cks_inc = 1'b0;
    tmo_inc = 1'b0;

    if (rx_valid) begin
      case (state_q)
        HUNT: begin
          if (rx_data == WT931_HDR) begin
            sum_d   = WT931_HDR;
            state_d = TYPE;
          end
        end
        TYPE: begin
          type_d  = rx_data;
          sum_d   = sum_q + rx_data;
          idx_d   = '0;
          state_d = PAYLOAD;
        end
        PAYLOAD: begin
          pay_d[idx_q] = rx_data;
          sum_d        = sum_q + rx_data;
          idx_d        = idx_q + 3'd1;
          if (idx_q == 3'(WT931_PAYLOAD_LEN - 1)) state_d = CKSUM;
        end
        CKSUM: begin
          state_d = HUNT;
          // Payload words are little-endian; packed byte order already yields {w2,w1,w0}.
          if (rx_data == sum_q) begin
            case (type_q)
              TYPE_ACC: begin
                acc_d    = pay_q[5:0];
                temp_d   = pay_q[7:6];
                upd_d[0] = 1'b1;
              end
              TYPE_GYR: begin
                gyr_d    = pay_q[5:0];
                upd_d[1] = 1'b1;
              end
              TYPE_ANG: begin
                ang_d    = pay_q[5:0];
                upd_d[2] = 1'b1;
              end
              default: ;
            endcase
          end else begin
            cks_inc = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (gap_expire) begin
      state_d = HUNT;
      tmo_inc = 1'b1;
    end

    cks_d = cks_q;
    tmo_d = tmo_q;
    if (clr_cnt) begin
      cks_d = '0;
      tmo_d = '0;
    end else begin
      if (cks_inc && (cks_q != '1)) cks_d = cks_q + ERR_CNT_W'(1);
      if (tmo_inc && (tmo_q != '1)) tmo_d = tmo_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= HUNT;
      type_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      pay_q   <= '0;
      acc_q   <= '0;
      gyr_q   <= '0;
      ang_q   <= '0;
      temp_q  <= '0;
      upd_q   <= '0;
      cks_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      pay_q   <= pay_d;
      acc_q   <= acc_d;
      gyr_q   <= gyr_d;
      ang_q   <= ang_d;
      temp_q  <= temp_d;
      upd_q   <= upd_d;
      cks_q   <= cks_d;
      tmo_q   <= tmo_d;
    end
  end

  assign acc_data      = acc_q;
  assign gyr_data      = gyr_q;
  assign ang_data      = ang_q;
  assign temp_data     = temp_q;
  assign upd           = upd_q;
  assign cksum_err_cnt = cks_q;
  assign tmo_err_cnt   = tmo_q;
  assign in_frame      = (state_q != HUNT);
endmodule
